// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register-file dump reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_dump_pkg;

   localparam int NUM_REGS_DEF = 16;
   localparam int ADDR_W_DEF   = 4;
   localparam int DATA_W_DEF   = 8;

   // Reader FSM state; ST_CSUM is only reachable when REG_DUMP_CHECKSUM_EN is defined.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_SEND  = 3'd2;
   localparam state_t ST_DONE  = 3'd3;
   localparam state_t ST_CSUM  = 3'd4;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file through one read port and streams every value out on valid/ready.
// Latency: start -> first beat valid 2 cycles; one beat per 2 cycles; done 1 cycle after last accept.
// Backpressure: beat held stable in SEND until out_ready; outputs are registered-state only.
// Optional REG_DUMP_CHECKSUM_EN appends one XOR-checksum beat (address 0) after the last register.
module reg_dump_reader
   import reg_dump_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;

`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] acc;
   logic              csum_beat;
`endif

   // FSM, address counter and beat capture; addr only moves on entry to FETCH,
   // so it doubles as the held read address outside FETCH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         addr      <= '0;
         out_data  <= '0;
         out_addr  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
         acc       <= '0;
         csum_beat <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr  <= '0;
                  state <= ST_FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
                  acc       <= '0;
                  csum_beat <= 1'b0;
`endif
               end
            end
            ST_FETCH: begin
               out_data <= rd_data;
               out_addr <= addr;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                  if (csum_beat) begin
                     state <= ST_DONE;
                  end else begin
                     acc <= acc ^ out_data;
                     if (addr == LAST_ADDR) begin
                        state <= ST_CSUM;
                     end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_FETCH;
                     end
                  end
`else
                  if (addr == LAST_ADDR) begin
                     state <= ST_DONE;
                  end else begin
                     addr  <= addr + 1'b1;
                     state <= ST_FETCH;
                  end
`endif
               end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum beat is staged like a register fetch, then sent through SEND.
            ST_CSUM: begin
               out_data  <= acc;
               out_addr  <= '0;
               csum_beat <= 1'b1;
               state     <= ST_SEND;
            end
`endif
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != ST_IDLE);
   assign rd_addr   = addr;
   assign out_valid = (state == ST_SEND);
   assign done      = (state == ST_DONE);

`ifdef REG_DUMP_CHECKSUM_EN
   assign out_last = out_valid && csum_beat;
`else
   assign out_last = out_valid && (addr == LAST_ADDR);
`endif

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential reader that walks the 16-entry CPU register file through one of its combinational read ports and streams every register value out over a valid/ready handshake. It sits beside the register file on the debug path, sharing a read-address port via the top-level mux while the core is halted, and feeds the debug/trace serialiser downstream. It is the read-side counterpart of the register-file write path: software or the debug FSM writes registers, this block dumps them.

## Interface
- NUM_REGS, 16, number of registers walked (addresses 0..NUM_REGS-1)
- ADDR_W, 4, register address width
- DATA_W, 8, register data width
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a dump; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE completes
- rd_addr  out  ADDR_W  read address driven to register-file read port
- rd_data  in  DATA_W  combinational read data returned for rd_addr
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat when high with out_valid
- out_data  out  DATA_W  beat payload
- out_addr  out  ADDR_W  register address of current beat
- out_last  out  1  marks final beat of the dump
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, FETCH, SEND, DONE (plus CSUM with macro).
- IDLE: start=1 -> addr counter cleared to 0, FETCH. start=0 -> stay.
- FETCH: rd_addr=addr; at edge, rd_data and addr captured into out_data/out_addr; -> SEND.
- SEND: out_valid=1; out_data/out_addr/out_last held stable until out_ready=1. On accept: addr==NUM_REGS-1 -> DONE (or CSUM); else addr+1, -> FETCH.
- DONE: done=1 for one cycle; -> IDLE.
- out_last=1 only on the final beat of the dump.
- start while busy: ignored, not queued.
- Register-file writes during a dump: each beat reflects the register's value at its FETCH edge; no snapshot coherency.
- rd_addr outside FETCH holds last value; 0 after reset.
- Reset asserted at any time: outputs immediately return to reset values, dump aborted, no done pulse.
- Reset values: busy=0, rd_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, done=0; state IDLE.

## Timing
- start sampled at edge E -> FETCH after E; beat k out_valid rises after edge E+1+2k.
- With out_ready held high: beat k accepted at edge E+2+2k; last beat (k=15) accepted at E+32; done high after E+32 for one cycle; IDLE after E+33.
- Throughput: one beat per 2 cycles; each cycle of out_ready=0 in SEND adds one cycle.
- No combinational path from out_ready to any output.

## Configuration
- REG_DUMP_CHECKSUM_EN defined: after register NUM_REGS-1 is accepted, CSUM state sends one extra beat with out_data = XOR of all NUM_REGS sent values, out_addr=0, out_last=1; register beat NUM_REGS-1 has out_last=0. DONE follows checksum acceptance (done after E+34 with out_ready high).
- Undefined: no CSUM state, no accumulator, NUM_REGS beats only, last register beat carries out_last.

## Structure
- Shared package reg_dump_pkg: state enum type, NUM_REGS/ADDR_W/DATA_W defaults.
- No sub-module is natural; counter, FSM and optional XOR accumulator live in one module.

## Test plan
- Preload rf[i]=8'h10+i, out_ready=1, start pulse -> 16 beats out_data 10..1F, out_addr 0..F, out_last only on beat 15, done one cycle after edge E+32.
- Same preload, out_ready low 3 cycles while beat 5 valid -> out_data=8'h15, out_addr=5 held stable, beat accepted on ready, total dump 3 cycles longer.
- start re-pulsed at E+10 -> ignored, exactly 16 beats, single done.
- reset asserted while beat 7 is valid -> out_valid/busy drop immediately, no done; new start after release dumps from address 0.
- Write rf[12]=8'hEE at E+5 -> beat 12 shows 8'hEE.
- REG_DUMP_CHECKSUM_EN, all rf=8'hA5 except rf[3]=8'h5A -> 17th beat out_data=8'hFF with out_last=1; beat 15 out_last=0.
